// File: rtl/key_event_if.sv
// Key-event bus: debounced key levels in, tracked-key code and event pulses out.
// key_release/key_repeat stand for release/repeat, which are reserved words.
interface key_event_if #(
  parameter int NKEYS = 8
);
  localparam int CODE_W = $clog2(NKEYS);

  logic [NKEYS-1:0]  key;
  logic [CODE_W-1:0] code;
  logic              held;
  logic              press;
  logic              key_release;
  logic              long_press;
  logic              key_repeat;

  modport master (
    output key,
    input  code, held, press, key_release, long_press, key_repeat
  );

  modport slave (
    input  key,
    output code, held, press, key_release, long_press, key_repeat
  );
endinterface

// File: rtl/key_event.sv
// Key event detector: tracks the lowest pressed key and emits press, release,
// long-press and auto-repeat pulses, all registered.
module key_event #(
  parameter int NKEYS      = 8,
  parameter int LONG_CNT   = 50_000_000,
  parameter int REPEAT_CNT = 10_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  key_event_if.slave  bus
);
  localparam int CODE_W  = $clog2(NKEYS);
  localparam int CNT_MAX = (LONG_CNT > REPEAT_CNT) ? LONG_CNT : REPEAT_CNT;
  localparam int CNT_W   = $clog2(CNT_MAX);
  localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CNT - 1);
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CNT - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HELD   = 2'd1,
    ST_REPEAT = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [NKEYS-1:0]  k_q, k_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CODE_W-1:0] code_q, code_d;
  logic              held_q, held_d;
  logic              press_q, press_d;
  logic              release_q, release_d;
  logic              long_q, long_d;
  logic              repeat_q, repeat_d;
  logic              tracked_s;
  logic              any_key_s;

  // Lowest-index set bit gives priority to key 0.
  function automatic logic [CODE_W-1:0] lowest_set(input logic [NKEYS-1:0] v);
    logic [CODE_W-1:0] idx;
    idx = '0;
    for (int i = NKEYS - 1; i >= 0; i--) begin
      if (v[i]) begin
        idx = CODE_W'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

  assign k_d       = bus.key;
  assign tracked_s = k_q[code_q];
  assign any_key_s = (k_q != '0);

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      k_q       <= '0;
      cnt_q     <= '0;
      code_q    <= '0;
      held_q    <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;
      repeat_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      cnt_q     <= cnt_d;
      code_q    <= code_d;
      held_q    <= held_d;
      press_q   <= press_d;
      release_q <= release_d;
      long_q    <= long_d;
      repeat_q  <= repeat_d;
    end
  end

  // Next-state decision; a dropped tracked key wins over any threshold.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (any_key_s) begin
          state_d = ST_HELD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_HELD: begin
        if (!tracked_s) begin
          state_d = ST_IDLE;
        end else if (cnt_q == LONG_LAST) begin
          state_d = ST_REPEAT;
        end else begin
          state_d = ST_HELD;
        end
      end
      ST_REPEAT: begin
        if (!tracked_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_REPEAT;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Counter, code latch and pulse generation for the transition being taken.
  always_comb begin
    cnt_d     = cnt_q;
    code_d    = code_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    long_d    = 1'b0;
    repeat_d  = 1'b0;
    held_d    = (state_d != ST_IDLE);
    case (state_q)
      ST_IDLE: begin
        if (any_key_s) begin
          code_d  = lowest_set(k_q);
          cnt_d   = '0;
          press_d = 1'b1;
        end else begin
          cnt_d = cnt_q;
        end
      end
      ST_HELD: begin
        if (!tracked_s) begin
          release_d = 1'b1;
          cnt_d     = '0;
        end else if (cnt_q == LONG_LAST) begin
          long_d = 1'b1;
          cnt_d  = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_REPEAT: begin
        if (!tracked_s) begin
          release_d = 1'b1;
          cnt_d     = '0;
        end else if (cnt_q == REPEAT_LAST) begin
          repeat_d = 1'b1;
          cnt_d    = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        cnt_d = '0;
      end
    endcase
  end

  assign bus.code        = code_q;
  assign bus.held        = held_q;
  assign bus.press       = press_q;
  assign bus.key_release = release_q;
  assign bus.long_press  = long_q;
  assign bus.key_repeat  = repeat_q;
endmodule

// File: doc/key_event.md
KEY_EVENT -- requirements
Module: key_event

Interface
REQ-001 Parameter NKEYS, default 8: number of debounced key inputs (2..16).
REQ-002 Parameter LONG_CNT, default 50_000_000: cycles held in HELD before the long-press pulse (>=2).
REQ-003 Parameter REPEAT_CNT, default 10_000_000: cycles between auto-repeat pulses (>=2).
REQ-004 Port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-005 Port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 Port key, input, NKEYS bits: debounced key levels from per-key anti_jitter stages; 1 means pressed.
REQ-007 Port code, output, $clog2(NKEYS) bits: index of the tracked key.
REQ-008 Port held, output, 1 bit: level; 1 while a key is tracked.
REQ-009 Port press, output, 1 bit: one-cycle pulse when tracking starts.
REQ-010 Port release, output, 1 bit: one-cycle pulse when the tracked key is released.
REQ-011 Port long_press, output, 1 bit: one-cycle pulse when the LONG_CNT threshold is reached.
REQ-012 Port repeat, output, 1 bit: one-cycle pulse every REPEAT_CNT cycles after long_press.

Function
REQ-013 key SHALL be registered once into k_q; the FSM SHALL act only on k_q.
REQ-014 The FSM SHALL have three states: IDLE, HELD and REPEAT.
REQ-015 Counter cnt SHALL be wide enough for max(LONG_CNT, REPEAT_CNT)-1 and SHALL never wrap.
REQ-016 IDLE with k_q != 0 SHALL:
- latch code = index of the lowest set bit of k_q;
- clear cnt;
- assert press for exactly the next cycle;
- enter HELD.
REQ-017 Latency SHALL be 2 edges: key high before edge t -> press and held high in the cycle after edge t+1.
REQ-018 IDLE with k_q == 0 SHALL hold code unchanged and keep all pulses low.
REQ-019 In HELD or REPEAT, keys other than k_q[code] SHALL be ignored.
REQ-020 HELD with k_q[code]=1 SHALL increment cnt.
REQ-021 HELD with cnt == LONG_CNT-1 SHALL:
- assert long_press for one cycle;
- clear cnt;
- enter REPEAT.
REQ-022 REPEAT with k_q[code]=1 SHALL increment cnt.
REQ-023 REPEAT with cnt == REPEAT_CNT-1 SHALL assert repeat for one cycle and clear cnt, staying in REPEAT.
REQ-024 HELD or REPEAT with k_q[code]=0 SHALL:
- assert release for one cycle;
- clear cnt;
- enter IDLE.
  This takes priority over long_press and repeat on the same edge.
REQ-025 held SHALL be 1 in HELD and REPEAT and 0 in IDLE, registered with the state.
REQ-026 A key still pressed when the FSM returns to IDLE SHALL be treated as a new press at the next edge.
- Consequence: press never coincides with release.
- Minimum gap between release and the next press is 1 cycle.
REQ-027 At most one of press, release, long_press and repeat SHALL be high in any cycle.

Reset
REQ-028 rst_n=0 SHALL immediately clear state, regardless of clock:
- state=IDLE;
- cnt=0, k_q=0, code=0;
- held, press, release, long_press and repeat = 0.
REQ-029 Reset asserted mid-hold SHALL NOT produce a release pulse.
REQ-030 A key still pressed after rst_n deasserts SHALL produce a fresh press through REQ-016.

Verification (NKEYS=4, LONG_CNT=8, REPEAT_CNT=4)
REQ-031 The bench SHALL cover a short press:
- stimulus: key=4'b0100 for 5 cycles, then 0;
- response: press with code=2 two edges after the rise; held high 5 cycles; release once; no long_press.
REQ-032 The bench SHALL cover long press with repeat:
- stimulus: key=4'b0001 held for 30 cycles;
- response: long_press 8 cycles after press; repeat every 4 cycles thereafter; release once at the end.
REQ-033 The bench SHALL cover priority and ignoring:
- stimulus: key=4'b1010, then bit 3 drops while bit 1 stays;
- response: code=1 and no new event; after bit 1 drops with bit 3 re-raised, release then press with code=3 one cycle later.
REQ-034 The bench SHALL cover a threshold collision:
- stimulus: tracked key released on the edge where cnt == LONG_CNT-1;
- response: release only, no long_press.
REQ-035 The bench SHALL cover reset mid-operation:
- stimulus: rst_n pulsed low while in REPEAT, key kept high;
- response: all outputs 0 asynchronously and no release; press fires 2 edges after rst_n rises.
